mcpu_ctrl_hs: RTL and testbench

//  Multi-cycle MIPS control FSM for the next-generation mCPU. Adds a req/ready memory

---
 rtl/mcpu_ctrl_hs.sv | 216 +++++++++++++++++++++
 tb/tb_mcpu_ctrl_hs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_hs.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake, wait-state timeout and sticky ERR.
// Outputs are combinational from state/op/func/Zero/mem_ready; only state and the wait counter are registered.
module mcpu_ctrl_hs #(
    parameter int TIMEOUT_W   = 4,
    parameter int TIMEOUT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       WritePC,
    output logic       IorD,
    output logic       WriteMem,
    output logic       WriteIR,
    output logic       WriteDR,
    output logic       WriteA,
    output logic       WriteB,
    output logic       WriteC,
    output logic       WriteReg,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtZero,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [1:0] PCSource,
    output logic [2:0] ALUC,
    output logic       err,
    output logic [3:0] state_out
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_EX_R = 4'd2, S_EX_MA = 4'd3, S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5, S_WB_R = 4'd6, S_WB_LW = 4'd7, S_EX_BR = 4'd8, S_EX_J = 4'd9,
        S_EX_JAL = 4'd10, S_EX_I = 4'd11, S_WB_I = 4'd12, S_ERR = 4'd15
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_MAX);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout;

    assign timeout   = (TIMEOUT_MAX != 0) && (cnt_q == TMAX);
    assign state_out = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_req  = 1'b0;
        WritePC  = 1'b0;
        IorD     = 1'b0;
        WriteMem = 1'b0;
        WriteIR  = 1'b0;
        WriteDR  = 1'b0;
        WriteA   = 1'b0;
        WriteB   = 1'b0;
        WriteC   = 1'b0;
        WriteReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        ExtZero  = 1'b0;
        RegDst   = 2'b00;
        MemToReg = 2'b00;
        PCSource = 2'b00;
        ALUC     = 3'b000;
        err      = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    WriteIR = 1'b1;
                    WritePC = 1'b1;
                    state_d = S_ID;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_ID: begin
                WriteA = 1'b1;
                WriteB = 1'b1;
                case (op)
                    OP_R:                              state_d = S_EX_R;
                    OP_LW, OP_SW:                      state_d = S_EX_MA;
                    OP_BEQ, OP_BNE:                    state_d = S_EX_BR;
                    OP_J:                              state_d = S_EX_J;
                    OP_JAL:                            state_d = S_EX_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EX_I;
                    default:                           state_d = S_ERR;
                endcase
            end
            S_EX_R: begin
                ALUSrcA = 1'b1;
                WriteC  = 1'b1;
                state_d = S_WB_R;
                case (func)
                    6'b100000: ALUC = 3'b000;
                    6'b100010: ALUC = 3'b001;
                    6'b100100: ALUC = 3'b010;
                    6'b100101: ALUC = 3'b011;
                    6'b100110: ALUC = 3'b100;
                    6'b100111: ALUC = 3'b101;
                    6'b000010: ALUC = 3'b110;
                    6'b101010: ALUC = 3'b111;
                    default:   state_d = S_ERR;
                endcase
            end
            S_WB_R: begin
                RegDst   = 2'b01;
                WriteReg = 1'b1;
                state_d  = S_IF;
            end
            S_EX_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 1'b1;
                WriteC  = 1'b1;
                if (op == OP_LW)      state_d = S_MEM_RD;
                else if (op == OP_SW) state_d = S_MEM_WR;
                else                  state_d = S_ERR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    WriteDR = 1'b1;
                    state_d = S_WB_LW;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB_LW: begin
                MemToReg = 2'b01;
                WriteReg = 1'b1;
                state_d  = S_IF;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                WriteMem = mem_ready;
                if (mem_ready)    state_d = S_IF;
                else if (timeout) state_d = S_ERR;
            end
            S_EX_BR: begin
                ALUSrcA  = 1'b1;
                ALUC     = 3'b001;
                PCSource = 2'b01;
                WritePC  = ((op == OP_BEQ) && Zero) || ((op == OP_BNE) && !Zero);
                state_d  = S_IF;
            end
            S_EX_J: begin
                WritePC  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_IF;
            end
            S_EX_JAL: begin
                // PC was already advanced in IF, so next_PC is the link address.
                WritePC  = 1'b1;
                PCSource = 2'b10;
                RegDst   = 2'b10;
                MemToReg = 2'b10;
                WriteReg = 1'b1;
                state_d  = S_IF;
            end
            S_EX_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 1'b1;
                WriteC  = 1'b1;
                state_d = S_WB_I;
                case (op)
                    OP_ADDI: ALUC = 3'b000;
                    OP_SLTI: ALUC = 3'b111;
                    OP_ANDI: begin ALUC = 3'b010; ExtZero = 1'b1; end
                    OP_ORI:  begin ALUC = 3'b011; ExtZero = 1'b1; end
                    default: state_d = S_ERR;
                endcase
            end
            S_WB_I: begin
                WriteReg = 1'b1;
                state_d  = S_IF;
            end
            S_ERR:   err = 1'b1;
            default: state_d = S_ERR;
        endcase

        // A completed access or any state change restarts the wait count.
        if ((state_d != state_q) || mem_ready)  cnt_d = '0;
        else if (mem_req)                       cnt_d = cnt_q + 1'b1;

        if (rst) begin
            mem_req  = 1'b0;
            WritePC  = 1'b0;
            WriteMem = 1'b0;
            WriteIR  = 1'b0;
            WriteDR  = 1'b0;
            WriteA   = 1'b0;
            WriteB   = 1'b0;
            WriteC   = 1'b0;
            WriteReg = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mcpu_ctrl_hs.sv
// Directed table-driven bench for mcpu_ctrl_hs plus hand sequences for timeout, ERR and reset.
module tb_mcpu_ctrl_hs;
    logic       clk, rst, Zero, mem_ready;
    logic [5:0] op, func;
    logic       mem_req, WritePC, IorD, WriteMem, WriteIR, WriteDR, WriteA, WriteB, WriteC, WriteReg;
    logic       ALUSrcA, ALUSrcB, ExtZero, err;
    logic [1:0] RegDst, MemToReg, PCSource;
    logic [2:0] ALUC;
    logic [3:0] state_out;
    logic [22:0] obs;

    mcpu_ctrl_hs #(.TIMEOUT_W(4), .TIMEOUT_MAX(15)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .WritePC(WritePC), .IorD(IorD), .WriteMem(WriteMem), .WriteIR(WriteIR),
        .WriteDR(WriteDR), .WriteA(WriteA), .WriteB(WriteB), .WriteC(WriteC), .WriteReg(WriteReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .RegDst(RegDst),
        .MemToReg(MemToReg), .PCSource(PCSource), .ALUC(ALUC), .err(err), .state_out(state_out)
    );

    assign obs = {mem_req, WritePC, IorD, WriteMem, WriteIR, WriteDR, WriteA, WriteB, WriteC, WriteReg,
                  ALUSrcA, ALUSrcB, ExtZero, RegDst, MemToReg, PCSource, ALUC, err};

    localparam logic [22:0] MREQ = 23'd1 << 22, WPC = 23'd1 << 21, IORD = 23'd1 << 20;
    localparam logic [22:0] WMEM = 23'd1 << 19, WIR = 23'd1 << 18, WDR = 23'd1 << 17;
    localparam logic [22:0] WA = 23'd1 << 16, WB = 23'd1 << 15, WC = 23'd1 << 14, WREG = 23'd1 << 13;
    localparam logic [22:0] ASA = 23'd1 << 12, ASB = 23'd1 << 11, EXTZ = 23'd1 << 10, ERRB = 23'd1;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;

    function automatic logic [22:0] rd(input logic [1:0] v);  return 23'(v) << 8; endfunction
    function automatic logic [22:0] mt(input logic [1:0] v);  return 23'(v) << 6; endfunction
    function automatic logic [22:0] pcs(input logic [1:0] v); return 23'(v) << 4; endfunction
    function automatic logic [22:0] al(input logic [2:0] v);  return 23'(v) << 1; endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [22:0] outs;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                       input logic [3:0] s, input logic [22:0] e);
        vec_t v;
        v.op = o; v.func = f; v.zero = z; v.rdy = r; v.st = s; v.outs = e;
        tv.push_back(v);
    endtask

    task automatic fd(input logic [5:0] o, input logic [5:0] f, input logic z);
        add(o, f, z, 1'b1, 4'd0, MREQ | WPC | WIR);
        add(o, f, z, 1'b1, 4'd1, WA | WB);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        op = o; func = f; Zero = z; mem_ready = r;
    endtask

    // Reset pulse starting just after a negedge; leaves the bench just after the next negedge in IF.
    task automatic do_reset(input int tag);
        rst = 1'b1;
        #1;
        chk("rst_state", tag, 32'(state_out), 32'd0);
        chk("rst_err", tag, 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(R, 6'b100000, 1'b0, 1'b1);
        #1;
        chk("reset_outs", 0, 32'(obs), 32'd0);
        chk("reset_state", 0, 32'(state_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fd(R, 6'b100000, 0); add(R, 6'b100000, 0, 1, 2, ASA | WC | al(0)); add(R, 6'b100000, 0, 1, 6, WREG | rd(1));
        fd(R, 6'b100010, 0); add(R, 6'b100010, 0, 1, 2, ASA | WC | al(1)); add(R, 6'b100010, 0, 1, 6, WREG | rd(1));
        fd(R, 6'b101010, 0); add(R, 6'b101010, 0, 1, 2, ASA | WC | al(7)); add(R, 6'b101010, 0, 1, 6, WREG | rd(1));
        fd(R, 6'b000010, 0); add(R, 6'b000010, 0, 1, 2, ASA | WC | al(6)); add(R, 6'b000010, 0, 1, 6, WREG | rd(1));
        for (int k = 0; k < 3; k++) add(LW, 0, 0, 0, 0, MREQ);
        add(LW, 0, 0, 1, 0, MREQ | WPC | WIR);
        add(LW, 0, 0, 1, 1, WA | WB);
        add(LW, 0, 0, 1, 3, ASA | ASB | WC | al(0));
        for (int k = 0; k < 3; k++) add(LW, 0, 0, 0, 4, MREQ | IORD);
        add(LW, 0, 0, 1, 4, MREQ | IORD | WDR);
        add(LW, 0, 0, 1, 7, WREG | mt(1));
        fd(SW, 0, 0); add(SW, 0, 0, 1, 3, ASA | ASB | WC);
        add(SW, 0, 0, 0, 5, MREQ | IORD); add(SW, 0, 0, 1, 5, MREQ | IORD | WMEM);
        fd(BNE, 0, 0); add(BNE, 0, 0, 1, 8, ASA | al(1) | pcs(1) | WPC);
        fd(BNE, 0, 1); add(BNE, 0, 1, 1, 8, ASA | al(1) | pcs(1));
        fd(BEQ, 0, 1); add(BEQ, 0, 1, 1, 8, ASA | al(1) | pcs(1) | WPC);
        fd(BEQ, 0, 0); add(BEQ, 0, 0, 1, 8, ASA | al(1) | pcs(1));
        fd(J, 0, 0);   add(J, 0, 0, 1, 9, WPC | pcs(2));
        fd(JAL, 0, 0); add(JAL, 0, 0, 1, 10, WPC | pcs(2) | rd(2) | mt(2) | WREG);
        fd(ADDI, 0, 0); add(ADDI, 0, 0, 1, 11, ASA | ASB | WC | al(0)); add(ADDI, 0, 0, 1, 12, WREG);
        fd(SLTI, 0, 0); add(SLTI, 0, 0, 1, 11, ASA | ASB | WC | al(7)); add(SLTI, 0, 0, 1, 12, WREG);
        fd(ANDI, 0, 0); add(ANDI, 0, 0, 1, 11, ASA | ASB | WC | EXTZ | al(2)); add(ANDI, 0, 0, 1, 12, WREG);
        fd(ORI, 0, 0);  add(ORI, 0, 0, 1, 11, ASA | ASB | WC | EXTZ | al(3)); add(ORI, 0, 0, 1, 12, WREG);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].op, tv[i].func, tv[i].zero, tv[i].rdy);
            #1;
            chk("vec_state", i, 32'(state_out), 32'(tv[i].st));
            chk("vec_outs", i, 32'(obs), 32'(tv[i].outs));
            @(negedge clk);
        end

        // Fetch never answered: 16 cycles in IF (count 0..15), then ERR.
        drive(R, 6'b100000, 0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("to_if_state", i, 32'(state_out), 32'd0);
            chk("to_if_req", i, 32'(mem_req), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("to_err_state", 0, 32'(state_out), 32'd15);
        chk("to_err_outs", 0, 32'(obs), 32'(ERRB));
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("err_sticky", 0, 32'(state_out), 32'd15);
        do_reset(1);
        chk("post_rst_err", 1, 32'(err), 32'd0);

        // Illegal opcode goes to ERR from ID.
        drive(6'b111111, 0, 0, 1);
        @(negedge clk);
        #1;
        chk("badop_id", 0, 32'(state_out), 32'd1);
        @(negedge clk);
        #1;
        chk("badop_err", 0, 32'(state_out), 32'd15);
        chk("badop_errflag", 0, 32'(err), 32'd1);
        do_reset(2);

        // Unknown R-type func goes to ERR from EX_R.
        drive(R, 6'b111111, 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("badfunc_err", 0, 32'(state_out), 32'd15);
        do_reset(3);

        // Store whose ready lands exactly on the limit count completes.
        drive(SW, 0, 0, 1);
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("sw_wait_state", i, 32'(state_out), 32'd5);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_limit_outs", 0, 32'(obs), 32'(MREQ | IORD | WMEM));
        @(negedge clk);
        #1;
        chk("sw_limit_state", 0, 32'(state_out), 32'd0);
        chk("sw_limit_err", 0, 32'(err), 32'd0);

        // Reset asserted in the middle of a load access.
        drive(LW, 0, 0, 1);
        @(negedge clk);
        #1;
        chk("mid_id", 0, 32'(state_out), 32'd1);
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("mid_memrd", 0, 32'(state_out), 32'd4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req_drop", 0, 32'(mem_req), 32'd0);
        chk("mid_state", 0, 32'(state_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("mid_restart", i, 32'(state_out), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("mid_timeout", 0, 32'(state_out), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
